vinstr_issue_queue: RTL and testbench

Decoupling queue and issue sequencer between the scalar core's vector-instruction port and the vector core's request/ready interface. Accepts instruction plus rs1/rs2 operands from the scalar core into a small FIFO, then issues one entry at a time to the vector core. Each entry is issued only when the vector core reports ready. Scalar operands are held stable across the vector core's operand-capture window.

---
 rtl/vect_pkg.sv | 20 ++
 rtl/vq_fifo.sv | 57 +++++
 rtl/vinstr_issue_queue.sv | 119 +++++++++++
 tb/tb_vinstr_issue_queue.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vect_pkg.sv
// Shared types for the vector-instruction issue queue: sequencer states and the
// queued entry layout (instruction word plus both scalar operands).
package vect_pkg;

   localparam int unsigned IQ_XLEN = 32;

   typedef enum logic [1:0] {
      IQ_IDLE,
      IQ_ISSUE,
      IQ_SETTLE,
      IQ_WAIT
   } issue_state_t;

   typedef struct packed {
      logic [IQ_XLEN-1:0] instr;
      logic [IQ_XLEN-1:0] rs1;
      logic [IQ_XLEN-1:0] rs2;
   } iq_entry_t;

endpackage

// File: rtl/vq_fifo.sv
// Small synchronous FIFO with flush; head entry is visible combinationally on rdata_o.
// Depth must be a power of two so the pointers wrap naturally.
module vq_fifo #(
   parameter int unsigned WIDTH = 96,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]  count_q;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CntW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // A full FIFO refuses the push even when a pop frees a slot in the same cycle.
   assign do_push = push_i && !full_o && !flush_i;
   assign do_pop  = pop_i && !empty_o && !flush_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
         else if (!do_push && do_pop) count_q <= count_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/vinstr_issue_queue.sv
// Decouples the scalar core's vector-instruction port from the vector core: entries are
// queued, then issued one at a time with a settle window before vready_i is trusted again.
module vinstr_issue_queue
   import vect_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = IQ_XLEN,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned SETTLE_CYC = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     sreq_i,
   input  logic [DATA_WIDTH-1:0]    sinstr_i,
   input  logic [DATA_WIDTH-1:0]    srs1_i,
   input  logic [DATA_WIDTH-1:0]    srs2_i,
   output logic                     sack_o,
   input  logic                     flush_i,
   output logic                     vreq_o,
   output logic [DATA_WIDTH-1:0]    vinstr_o,
   output logic [DATA_WIDTH-1:0]    vrs1_o,
   output logic [DATA_WIDTH-1:0]    vrs2_o,
   input  logic                     vready_i,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   pending_o,
   output logic                     busy_o
);

   localparam int unsigned SetW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   issue_state_t          state_q, state_d;
   logic [SetW-1:0]       settle_q, settle_d;
   logic [DATA_WIDTH-1:0] vinstr_q, vrs1_q, vrs2_q;
   logic                  busy_q;

   iq_entry_t             wr_entry, head;
   logic                  fifo_full, fifo_empty;
   logic [$clog2(DEPTH):0] fifo_count;
   logic                  issue;

   // Entry layout is fixed by iq_entry_t, so DATA_WIDTH is expected to equal IQ_XLEN.
   always_comb begin
      wr_entry       = '0;
      wr_entry.instr = sinstr_i;
      wr_entry.rs1   = srs1_i;
      wr_entry.rs2   = srs2_i;
   end

   vq_fifo #(
      .WIDTH ($bits(iq_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (sreq_i),
      .pop_i   (issue),
      .flush_i (flush_i),
      .wdata_i (wr_entry),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // No bypass: an entry must already sit in the FIFO before it can be issued.
   assign issue  = (state_q == IQ_IDLE) && !fifo_empty && vready_i && !flush_i;
   assign sack_o = sreq_i && !fifo_full && !flush_i;

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      unique case (state_q)
         IQ_IDLE: begin
            if (issue) state_d = IQ_ISSUE;
         end
         IQ_ISSUE: begin
            settle_d = SetW'(SETTLE_CYC - 1);
            state_d  = IQ_SETTLE;
         end
         IQ_SETTLE: begin
            if (settle_q == '0) state_d = IQ_WAIT;
            else                settle_d = settle_q - SetW'(1);
         end
         IQ_WAIT: begin
            if (vready_i) state_d = IQ_IDLE;
         end
         default: state_d = IQ_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IQ_IDLE;
         settle_q <= '0;
         vinstr_q <= '0;
         vrs1_q   <= '0;
         vrs2_q   <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         busy_q   <= (state_q != IQ_IDLE) || !fifo_empty;
         // Operands load only on pop so the vector core's late capture sees stable values.
         if (issue) begin
            vinstr_q <= head.instr;
            vrs1_q   <= head.rs1;
            vrs2_q   <= head.rs2;
         end
      end
   end

   assign vreq_o    = (state_q == IQ_ISSUE);
   assign vinstr_o  = vinstr_q;
   assign vrs1_o    = vrs1_q;
   assign vrs2_o    = vrs2_q;
   assign full_o    = fifo_full;
   assign pending_o = fifo_count;
   assign busy_o    = busy_q;

endmodule

// File: tb/tb_vinstr_issue_queue.sv
// Self-checking bench for vinstr_issue_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the issue rules.
module tb_vinstr_issue_queue;

   localparam int DW     = 32;
   localparam int DEPTH  = 4;
   localparam int SETTLE = 2;
   localparam int PW     = $clog2(DEPTH) + 1;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          sreq_i = 1'b0;
   logic [DW-1:0] sinstr_i = '0, srs1_i = '0, srs2_i = '0;
   logic          sack_o;
   logic          flush_i = 1'b0;
   logic          vreq_o;
   logic [DW-1:0] vinstr_o, vrs1_o, vrs2_o;
   logic          vready_i = 1'b0;
   logic          full_o;
   logic [PW-1:0] pending_o;
   logic          busy_o;

   always #5 clk_i = ~clk_i;

   vinstr_issue_queue #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .SETTLE_CYC (SETTLE)
   ) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .sreq_i    (sreq_i),
      .sinstr_i  (sinstr_i),
      .srs1_i    (srs1_i),
      .srs2_i    (srs2_i),
      .sack_o    (sack_o),
      .flush_i   (flush_i),
      .vreq_o    (vreq_o),
      .vinstr_o  (vinstr_o),
      .vrs1_o    (vrs1_o),
      .vrs2_o    (vrs2_o),
      .vready_i  (vready_i),
      .full_o    (full_o),
      .pending_o (pending_o),
      .busy_o    (busy_o)
   );

   typedef struct {
      logic [DW-1:0] i;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
   } ent_t;

   // Reference model: a queue of waiting entries, a lockout after each issue during which
   // vready_i is ignored, then a required vready_i sighting before the next issue.
   ent_t          mq[$];
   int            m_lock;
   bit            m_need;
   logic          exp_vreq, exp_full, exp_busy;
   logic [DW-1:0] exp_instr, exp_a, exp_b;
   logic [PW-1:0] exp_pending;

   int checks = 0;
   int errors = 0;
   ent_t fill_data[4];

   function automatic bit m_sack();
      return sreq_i && (mq.size() < DEPTH) && !flush_i;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_lock = 0;
      m_need = 0;
      exp_vreq = 0; exp_full = 0; exp_busy = 0;
      exp_instr = '0; exp_a = '0; exp_b = '0; exp_pending = '0;
   endtask

   task automatic tick();
      bit inflight, do_issue, push_ok;
      ent_t e;
      inflight = (m_lock > 0) || m_need;
      push_ok  = m_sack();
      do_issue = !inflight && (mq.size() > 0) && vready_i && !flush_i;
      exp_busy = inflight || (mq.size() != 0);
      if (m_lock > 0) m_lock--;
      else if (m_need && vready_i) m_need = 0;
      if (do_issue) begin
         e = mq.pop_front();
         exp_instr = e.i; exp_a = e.a; exp_b = e.b;
         m_lock = SETTLE + 1;
         m_need = 1;
      end
      if (flush_i) mq.delete();
      else if (push_ok) mq.push_back('{sinstr_i, srs1_i, srs2_i});
      exp_vreq    = do_issue;
      exp_pending = PW'(mq.size());
      exp_full    = (mq.size() == DEPTH);
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive_push(input bit req);
      sreq_i   = req;
      sinstr_i = $urandom;
      srs1_i   = $urandom;
      srs2_i   = $urandom;
   endtask

   task automatic test_reset();
      model_reset();
      repeat (2) @(posedge clk_i);
      #1;
      checks++; if (vreq_o !== 1'b0) $display("FAIL reset_vreq: got %0b want 0", vreq_o);
      if (vreq_o !== 1'b0) errors++;
      checks++;
      if ({vinstr_o, vrs1_o, vrs2_o} !== '0) begin
         errors++; $display("FAIL reset_data: got %h/%h/%h want 0", vinstr_o, vrs1_o, vrs2_o);
      end
      checks++;
      if (full_o !== 1'b0 || pending_o !== '0 || busy_o !== 1'b0 || sack_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_status: full=%b pending=%0d busy=%b sack=%b want 0", full_o,
                  pending_o, busy_o, sack_o);
      end
      rst_i = 1'b0;
   endtask

   task automatic test_single();
      sreq_i = 1; sinstr_i = 32'h0000_0057; srs1_i = 32'd5; srs2_i = 32'd7; vready_i = 1;
      #1;
      checks++;
      if (sack_o !== 1'b1) begin errors++; $display("FAIL single_sack: got %b want 1", sack_o); end
      tick();
      sreq_i = 0;
      checks++;
      if (vreq_o !== 1'b0 || pending_o !== PW'(1)) begin
         errors++; $display("FAIL single_queued: vreq=%b pending=%0d want 0/1", vreq_o, pending_o);
      end
      tick();
      checks++;
      if (vreq_o !== 1'b1 || vinstr_o !== 32'h57 || vrs1_o !== 32'd5 || vrs2_o !== 32'd7) begin
         errors++;
         $display("FAIL single_issue: vreq=%b %h/%h/%h want 1 57/5/7", vreq_o, vinstr_o, vrs1_o,
                  vrs2_o);
      end
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++;
         if (vreq_o !== exp_vreq || vinstr_o !== 32'h57 || vrs1_o !== 32'd5 ||
             vrs2_o !== 32'd7 || busy_o !== exp_busy) begin
            errors++;
            $display("FAIL single_hold[%0d]: vreq=%b instr=%h busy=%b want %b 57 %b", k, vreq_o,
                     vinstr_o, busy_o, exp_vreq, exp_busy);
         end
      end
   endtask

   task automatic test_fill();
      vready_i = 0;
      for (int k = 0; k < 5; k++) begin
         drive_push(1);
         if (k < 4) fill_data[k] = '{sinstr_i, srs1_i, srs2_i};
         #1;
         checks++;
         if (sack_o !== (k < 4)) begin
            errors++; $display("FAIL fill_sack[%0d]: got %b want %b", k, sack_o, (k < 4));
         end
         tick();
         checks++;
         if (vreq_o !== 1'b0) begin errors++; $display("FAIL fill_vreq[%0d]: got 1 want 0", k); end
      end
      sreq_i = 0;
      checks++;
      if (full_o !== 1'b1 || pending_o !== PW'(4)) begin
         errors++; $display("FAIL fill_full: full=%b pending=%0d want 1/4", full_o, pending_o);
      end
   endtask

   task automatic test_order();
      int n, last;
      n = 0; last = -1;
      vready_i = 1;
      for (int c = 0; c < 24; c++) begin
         tick();
         checks++;
         if (vreq_o !== exp_vreq) begin
            errors++; $display("FAIL order_vreq[%0d]: got %b want %b", c, vreq_o, exp_vreq);
         end
         if (vreq_o === 1'b1) begin
            checks++;
            if (n >= 4 || vinstr_o !== fill_data[n].i || vrs1_o !== fill_data[n].a ||
                vrs2_o !== fill_data[n].b) begin
               errors++; $display("FAIL order_data[%0d]: got %h pulse %0d", c, vinstr_o, n);
            end
            if (last >= 0) begin
               checks++;
               if (c - last != SETTLE + 3) begin
                  errors++; $display("FAIL order_spacing: got %0d want %0d", c - last, SETTLE + 3);
               end
            end
            last = c; n++;
         end
      end
      checks++;
      if (n != 4) begin errors++; $display("FAIL order_count: got %0d want 4", n); end
   endtask

   task automatic test_stall();
      ent_t b;
      vready_i = 1;
      drive_push(1); tick();
      drive_push(1); b = '{sinstr_i, srs1_i, srs2_i}; tick();
      sreq_i = 0; vready_i = 0;
      checks++;
      if (vreq_o !== 1'b1) begin errors++; $display("FAIL stall_first: got %b want 1", vreq_o); end
      for (int k = 0; k < 13; k++) begin
         tick();
         checks++;
         if (vreq_o !== 1'b0) begin errors++; $display("FAIL stall_hold[%0d]: got 1 want 0", k); end
      end
      vready_i = 1;
      tick();
      checks++;
      if (vreq_o !== 1'b0) begin errors++; $display("FAIL stall_early: got 1 want 0"); end
      tick();
      checks++;
      if (vreq_o !== 1'b1 || vinstr_o !== b.i) begin
         errors++; $display("FAIL stall_resume: vreq=%b instr=%h want 1 %h", vreq_o, vinstr_o, b.i);
      end
      repeat (5) tick();
   endtask

   task automatic test_flush();
      int pulses;
      vready_i = 1;
      for (int k = 0; k < 4; k++) begin
         drive_push(1); tick();
      end
      checks++;
      if (pending_o !== PW'(3) || busy_o !== 1'b1) begin
         errors++; $display("FAIL flush_pre: pending=%0d busy=%b want 3/1", pending_o, busy_o);
      end
      vready_i = 0; flush_i = 1; drive_push(1);
      #1;
      checks++;
      if (sack_o !== 1'b0) begin errors++; $display("FAIL flush_sack: got %b want 0", sack_o); end
      tick();
      flush_i = 0; sreq_i = 0;
      checks++;
      if (pending_o !== '0 || full_o !== 1'b0 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL flush_clear: pending=%0d full=%b busy=%b want 0/0/1", pending_o, full_o,
                  busy_o);
      end
      vready_i = 1; pulses = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (vreq_o === 1'b1) pulses++;
         checks++;
         if (busy_o !== exp_busy) begin
            errors++; $display("FAIL flush_busy[%0d]: got %b want %b", k, busy_o, exp_busy);
         end
      end
      checks++;
      if (pulses != 0 || busy_o !== 1'b0) begin
         errors++; $display("FAIL flush_drain: pulses=%0d busy=%b want 0/0", pulses, busy_o);
      end
   endtask

   task automatic test_reset_mid();
      ent_t y;
      vready_i = 1;
      drive_push(1); tick();
      drive_push(1); tick();
      sreq_i = 0; tick();
      #2 rst_i = 1;
      #1;
      checks++;
      if (vreq_o !== 1'b0 || {vinstr_o, vrs1_o, vrs2_o} !== '0 || pending_o !== '0 ||
          full_o !== 1'b0 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL resetmid_clear: vreq=%b instr=%h pending=%0d busy=%b want 0", vreq_o,
                  vinstr_o, pending_o, busy_o);
      end
      model_reset();
      @(posedge clk_i); #1;
      rst_i = 0;
      drive_push(1); y = '{sinstr_i, srs1_i, srs2_i}; tick();
      sreq_i = 0; tick();
      checks++;
      if (vreq_o !== 1'b1 || vinstr_o !== y.i || vrs1_o !== y.a || vrs2_o !== y.b) begin
         errors++; $display("FAIL resetmid_issue: vreq=%b instr=%h want 1 %h", vreq_o, vinstr_o, y.i);
      end
      repeat (5) tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         drive_push($urandom_range(0, 99) < 60);
         flush_i  = ($urandom_range(0, 99) < 4);
         vready_i = ($urandom_range(0, 99) < 50);
         #1;
         checks++;
         if (sack_o !== m_sack()) begin
            errors++; $display("FAIL rand_sack[%0d]: got %b want %b", c, sack_o, m_sack());
         end
         tick();
         checks++;
         if (vreq_o !== exp_vreq || vinstr_o !== exp_instr || vrs1_o !== exp_a ||
             vrs2_o !== exp_b || full_o !== exp_full || pending_o !== exp_pending ||
             busy_o !== exp_busy) begin
            errors++;
            $display("FAIL rand_out[%0d]: got vreq=%b instr=%h rs1=%h rs2=%h full=%b pend=%0d busy=%b want %b %h %h %h %b %0d %b",
                     c, vreq_o, vinstr_o, vrs1_o, vrs2_o, full_o, pending_o, busy_o, exp_vreq,
                     exp_instr, exp_a, exp_b, exp_full, exp_pending, exp_busy);
         end
      end
      sreq_i = 0; flush_i = 0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_order();
      test_stall();
      test_flush();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
